// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: serializes core fetch and data accesses onto a single
// sram-like master port. Data accesses win over fetches because the M-stage
// instruction is older. Returned data is held, and the matching stall stays
// low, until the core's global stall releases.
module sram_like_arbiter (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        instrStall,
  // data side
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        dataStall,
  // core global stall
  input  logic        longest_stall,
  // sram-like master port
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_t;

  state_t      state_r;
  logic        i_done_r;
  logic        d_done_r;
  logic        i_pend_s;
  logic        d_pend_s;
  logic        i_set_s;
  logic        d_set_s;
  logic [3:0]  wr_dec_s;
  logic        unused_s;

  // Map byte-enables to {size, addr[1:0]}; odd patterns fall back to a word.
  function automatic logic [3:0] write_decode(input logic [3:0] wen);
    logic [3:0] res;
    case (wen)
      4'b1111: res = {2'd2, 2'b00};
      4'b0011: res = {2'd1, 2'b00};
      4'b1100: res = {2'd1, 2'b10};
      4'b0001: res = {2'd0, 2'b00};
      4'b0010: res = {2'd0, 2'b01};
      4'b0100: res = {2'd0, 2'b10};
      4'b1000: res = {2'd0, 2'b11};
      default: res = {2'd2, 2'b00};
    endcase
    return res;
  endfunction

  // Pending/complete conditions and the write size/offset decode.
  always_comb begin
    i_pend_s = inst_en & ~i_done_r;
    d_pend_s = data_en & ~d_done_r;
    i_set_s  = (state_r == I_DATA) & data_ok & inst_en;
    d_set_s  = (state_r == D_DATA) & data_ok & data_en;
    wr_dec_s = write_decode(data_wen);
  end

  assign instrStall = i_pend_s;
  assign dataStall  = d_pend_s;

  // Word alignment drops the low address bits of the request inputs.
  assign unused_s = ^{inst_addr[1:0], data_addr[1:0]};

  // Bus FSM: pick a side in IDLE, hold req until accepted, capture the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      req        <= 1'b0;
      wr         <= 1'b0;
      size       <= 2'd0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (d_pend_s) begin
            state_r <= D_ADDR;
            req     <= 1'b1;
            wdata   <= data_wdata;
            if (data_wen != 4'b0000) begin
              wr   <= 1'b1;
              size <= wr_dec_s[3:2];
              addr <= {data_addr[31:2], wr_dec_s[1:0]};
            end else begin
              wr   <= 1'b0;
              size <= 2'd2;
              addr <= {data_addr[31:2], 2'b00};
            end
          end else if (i_pend_s) begin
            state_r <= I_ADDR;
            req     <= 1'b1;
            wr      <= 1'b0;
            size    <= 2'd2;
            addr    <= {inst_addr[31:2], 2'b00};
          end
        end
        I_ADDR: begin
          if (addr_ok) begin
            req     <= 1'b0;
            state_r <= I_DATA;
          end
        end
        I_DATA: begin
          if (data_ok) begin
            state_r <= IDLE;
            if (inst_en) begin
              inst_rdata <= rdata;
            end
          end
        end
        D_ADDR: begin
          if (addr_ok) begin
            req     <= 1'b0;
            state_r <= D_DATA;
          end
        end
        D_DATA: begin
          if (data_ok) begin
            state_r <= IDLE;
            if (data_en & ~wr) begin
              data_rdata <= rdata;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          req     <= 1'b0;
        end
      endcase
    end
  end

  // Done flags: set on a kept response, cleared when the pipeline advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
    end else begin
      if (i_set_s) begin
        i_done_r <= 1'b1;
      end else if (!longest_stall) begin
        i_done_r <= 1'b0;
      end
      if (d_set_s) begin
        d_done_r <= 1'b1;
      end else if (!longest_stall) begin
        d_done_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: transaction-level reference model, a per-cycle
// compare process, directed scenarios with literal expectations, and a
// randomized phase with a randomly responding bus slave.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        instrStall;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        dataStall;
  logic        longest_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // reference model: one transaction record plus the held results
  bit          m_busy;
  bit          m_acc;
  bit          m_is_data;
  bit          m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_i_done;
  bit          m_d_done;
  logic [31:0] m_inst_rdata;
  logic [31:0] m_data_rdata;

  logic [3:0]  wen_tab [0:9];

  sram_like_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .instrStall(instrStall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .dataStall(dataStall),
    .longest_stall(longest_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_is_data = 0; m_wr = 0;
    m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0;
    m_i_done = 0; m_d_done = 0;
    m_inst_rdata = 32'd0; m_data_rdata = 32'd0;
  endtask

  // byte enables -> size and byte offset, from the rule table
  task automatic model_decode(input logic [3:0] wen, output logic [1:0] sz, output logic [1:0] off);
    sz = 2'd2; off = 2'd0;
    if (wen == 4'b0011) begin
      sz = 2'd1;
    end else if (wen == 4'b1100) begin
      sz = 2'd1; off = 2'd2;
    end else if ($countones(wen) == 1) begin
      sz = 2'd0;
      for (int k = 0; k < 4; k++) if (wen[k]) off = k[1:0];
    end
  endtask

  // advance the model by one clock edge using the inputs seen at that edge
  task automatic model_update();
    bit ip, dp, si, sd;
    logic [1:0] off;
    ip = inst_en & ~m_i_done;
    dp = data_en & ~m_d_done;
    si = 0; sd = 0;
    if (!m_busy) begin
      if (dp) begin
        m_busy = 1; m_acc = 0; m_is_data = 1;
        if (data_wen != 4'd0) begin
          m_wr = 1;
          model_decode(data_wen, m_size, off);
          m_addr = {data_addr[31:2], off};
          m_wdata = data_wdata;
        end else begin
          m_wr = 0; m_size = 2'd2; m_addr = {data_addr[31:2], 2'b00};
        end
      end else if (ip) begin
        m_busy = 1; m_acc = 0; m_is_data = 0;
        m_wr = 0; m_size = 2'd2; m_addr = {inst_addr[31:2], 2'b00};
      end
    end else if (!m_acc) begin
      if (addr_ok) m_acc = 1;
    end else if (data_ok) begin
      m_busy = 0;
      if (m_is_data) begin
        if (data_en) begin
          sd = 1;
          if (!m_wr) m_data_rdata = rdata;
        end
      end else if (inst_en) begin
        si = 1;
        m_inst_rdata = rdata;
      end
    end
    m_i_done = si | (m_i_done & longest_stall);
    m_d_done = sd | (m_d_done & longest_stall);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
  endtask

  // per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("req", {31'd0, req}, {31'd0, m_busy & ~m_acc});
      check("instrStall", {31'd0, instrStall}, {31'd0, inst_en & ~m_i_done});
      check("dataStall", {31'd0, dataStall}, {31'd0, data_en & ~m_d_done});
      check("inst_rdata", inst_rdata, m_inst_rdata);
      check("data_rdata", data_rdata, m_data_rdata);
      if (m_busy && !m_acc) begin
        check("wr", {31'd0, wr}, {31'd0, m_wr});
        check("size", {30'd0, size}, {30'd0, m_size});
        check("addr", addr, m_addr);
        if (m_wr) check("wdata", wdata, m_wdata);
      end
    end
  end

  initial begin
    wen_tab[0] = 4'b0000; wen_tab[1] = 4'b0000; wen_tab[2] = 4'b0000;
    wen_tab[3] = 4'b1111; wen_tab[4] = 4'b0011; wen_tab[5] = 4'b1100;
    wen_tab[6] = 4'b0001; wen_tab[7] = 4'b0010; wen_tab[8] = 4'b0100;
    wen_tab[9] = 4'b1000;
    rst = 1'b1;
    inst_en = 0; inst_addr = 32'd0; data_en = 0; data_wen = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0; longest_stall = 1'b1;
    addr_ok = 0; data_ok = 0; rdata = 32'd0;
    model_reset();
    #2;
    check("rst req", {31'd0, req}, 32'd0);
    check("rst addr", addr, 32'd0);
    check("rst size", {30'd0, size}, 32'd0);
    check("rst inst_rdata", inst_rdata, 32'd0);
    cycle();
    cmp_en = 1'b1;
    cycle();
    rst = 1'b0;

    // single fetch
    inst_en = 1; inst_addr = 32'hBFC0_0000;
    cycle();
    check("fetch req", {31'd0, req}, 32'd1);
    check("fetch addr", addr, 32'hBFC0_0000);
    check("fetch size", {30'd0, size}, 32'd2);
    check("fetch wr", {31'd0, wr}, 32'd0);
    cycle(); cycle();
    addr_ok = 1; cycle(); addr_ok = 0;
    cycle(); cycle();
    data_ok = 1; rdata = 32'h3C08_BFAF; cycle(); data_ok = 0; rdata = 32'd0;
    check("fetch stall low", {31'd0, instrStall}, 32'd0);
    check("fetch rdata", inst_rdata, 32'h3C08_BFAF);

    // hold under global stall, then clear and refetch
    repeat (10) cycle();
    check("hold rdata", inst_rdata, 32'h3C08_BFAF);
    check("hold no req", {31'd0, req}, 32'd0);
    longest_stall = 0; cycle(); longest_stall = 1;
    check("cleared stall", {31'd0, instrStall}, 32'd1);
    check("cleared idle", {31'd0, req}, 32'd0);
    cycle();
    check("refetch req", {31'd0, req}, 32'd1);
    addr_ok = 1; cycle(); addr_ok = 0;
    data_ok = 1; rdata = 32'h1111_1111; cycle(); data_ok = 0;
    inst_en = 0; longest_stall = 0; cycle(); longest_stall = 1;

    // simultaneous requests: data first, one IDLE bubble, then fetch
    inst_en = 1; inst_addr = 32'hBFC0_0040;
    data_en = 1; data_wen = 4'b0000; data_addr = 32'h8000_0004;
    cycle();
    check("sim first addr", addr, 32'h8000_0004);
    check("sim first wr", {31'd0, wr}, 32'd0);
    addr_ok = 1; cycle(); addr_ok = 0;
    data_ok = 1; rdata = 32'h1234_5678; cycle(); data_ok = 0;
    check("sim dataStall", {31'd0, dataStall}, 32'd0);
    check("sim instrStall", {31'd0, instrStall}, 32'd1);
    check("sim bubble", {31'd0, req}, 32'd0);
    check("sim data_rdata", data_rdata, 32'h1234_5678);
    cycle();
    check("sim fetch req", {31'd0, req}, 32'd1);
    check("sim fetch addr", addr, 32'hBFC0_0040);
    addr_ok = 1; cycle(); addr_ok = 0;
    data_ok = 1; rdata = 32'h0000_ABCD; cycle(); data_ok = 0;
    check("sim fetch done", {31'd0, instrStall}, 32'd0);
    inst_en = 0; data_en = 0; longest_stall = 0; cycle(); longest_stall = 1;

    // byte write then half write
    data_en = 1; data_wen = 4'b0100; data_addr = 32'h8000_0012; data_wdata = 32'h00AB_0000;
    cycle();
    check("byte wr", {31'd0, wr}, 32'd1);
    check("byte size", {30'd0, size}, 32'd0);
    check("byte addr", addr, 32'h8000_0012);
    check("byte wdata", wdata, 32'h00AB_0000);
    addr_ok = 1; cycle(); addr_ok = 0;
    data_ok = 1; rdata = 32'hFFFF_FFFF; cycle(); data_ok = 0;
    check("byte rdata kept", data_rdata, 32'h1234_5678);
    longest_stall = 0; cycle(); longest_stall = 1;
    data_wen = 4'b1100;
    cycle();
    check("half size", {30'd0, size}, 32'd1);
    check("half addr", addr, 32'h8000_0012);
    addr_ok = 1; cycle(); addr_ok = 0;
    data_ok = 1; rdata = 32'hEEEE_EEEE; cycle(); data_ok = 0;
    check("half rdata kept", data_rdata, 32'h1234_5678);
    data_en = 0; data_wen = 4'd0; longest_stall = 0; cycle(); longest_stall = 1;

    // exception drop during I_DATA
    inst_en = 1; inst_addr = 32'hBFC0_0080;
    cycle();
    addr_ok = 1; cycle(); addr_ok = 0;
    inst_en = 0; cycle();
    data_ok = 1; rdata = 32'hDEAD_BEEF; cycle(); data_ok = 0;
    check("drop rdata", inst_rdata, 32'h0000_ABCD);
    check("drop stall", {31'd0, instrStall}, 32'd0);
    inst_en = 1; #1;
    check("drop not done", {31'd0, instrStall}, 32'd1);
    inst_en = 0;
    cycle();

    // reset in D_DATA, then a fresh data request
    data_en = 1; data_wen = 4'd0; data_addr = 32'h8000_0100;
    cycle();
    addr_ok = 1; cycle(); addr_ok = 0;
    #1; rst = 1'b1; model_reset(); #1;
    check("mid rst req", {31'd0, req}, 32'd0);
    check("mid rst addr", addr, 32'd0);
    check("mid rst size", {30'd0, size}, 32'd0);
    check("mid rst inst_rdata", inst_rdata, 32'd0);
    check("mid rst data_rdata", data_rdata, 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    check("post rst req", {31'd0, req}, 32'd1);
    check("post rst addr", addr, 32'h8000_0100);
    addr_ok = 1; cycle(); addr_ok = 0;
    data_ok = 1; rdata = 32'h5555_AAAA; cycle(); data_ok = 0;
    data_en = 0; longest_stall = 0; cycle(); longest_stall = 1;

    // randomized traffic with a random slave and occasional async resets
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if ($urandom_range(0, 7) == 0) begin
        inst_en = ~inst_en; inst_addr = $urandom;
      end
      if ($urandom_range(0, 7) == 0) begin
        data_en = ~data_en; data_addr = $urandom; data_wdata = $urandom;
        if ($urandom_range(0, 10) == 0) data_wen = 4'($urandom_range(0, 15));
        else data_wen = wen_tab[$urandom_range(0, 9)];
      end
      longest_stall = ($urandom_range(0, 3) != 0);
      addr_ok = ($urandom_range(0, 2) == 0);
      data_ok = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        model_reset();
      end
    end
    cycle();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Sits between the core's SRAM-style fetch and memory ports and a single sram-like master port toward the AXI bridge. It serializes instruction and data requests (data has priority), generates `instrStall`/`dataStall` for the hazard unit, and holds returned read data until the core's global stall (`longest_stall`) releases. One transaction is outstanding at a time.

## Interface
No parameters; all addresses and data are 32 bits.

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- inst_en  in  1  fetch request; driven by core `instr_enF`, low while an exception is in M
- inst_addr  in  32  fetch address (`pcF`)
- inst_rdata  out  32  held fetch data
- instrStall  out  1  fetch not yet satisfied
- data_en  in  1  data access request (`mem_enM`)
- data_wen  in  4  byte write enables; 0 means read
- data_addr  in  32  data address (`aluoutM`)
- data_wdata  in  32  write data, already byte-lane aligned
- data_rdata  out  32  held read data (full word)
- dataStall  out  1  data access not yet satisfied
- longest_stall  in  1  core global stall; low in a cycle means the pipeline advances at the next edge
- req  out  1  bus request
- wr  out  1  1 for write
- size  out  2  0 = byte, 1 = half, 2 = word
- addr  out  32  bus address
- wdata  out  32  bus write data
- addr_ok  in  1  request accepted
- data_ok  in  1  response or write completion
- rdata  in  32  bus read data

## Operation
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Per-side flags `i_done`, `d_done`. Pending conditions: `i_pend = inst_en & ~i_done`, `d_pend = data_en & ~d_done`.
- Stall outputs are combinational: `instrStall = i_pend`, `dataStall = d_pend`.
- IDLE transitions:
  - `d_pend` → D_ADDR.
  - Else `i_pend` → I_ADDR.
  - Both pending: data wins, because the M-stage instruction is older.
- Bus fields are registered on entry to x_ADDR and held stable until `addr_ok`.
- Fetch bus fields: `wr=0`, `size=2`, `addr={inst_addr[31:2],2'b00}`.
- Data read bus fields: `wr=0`, `size=2`, `addr={data_addr[31:2],2'b00}`.
- Data write bus fields: `wr=1`, `wdata=data_wdata`. `size` and `addr[1:0]` come from `data_wen`:
  - 1111 → size 2, offset 00
  - 0011 → size 1, offset 00
  - 1100 → size 1, offset 10
  - single bit k → size 0, offset k
  - Any other `data_wen` pattern is treated as size 2, offset 00.
- x_ADDR: `req=1` until the cycle `addr_ok=1`, then go to x_DATA with `req=0`.
  - `req` is never withdrawn early, even if the `*_en` input drops.
- x_DATA: on `data_ok=1` return to IDLE.
  - I_DATA: if `inst_en=1` in that cycle, `inst_rdata<=rdata` and `i_done<=1`. If `inst_en=0`, the response is discarded and `i_done` is unchanged.
  - D_DATA: if `data_en=1`, `d_done<=1`. Reads also do `data_rdata<=rdata`; writes leave `data_rdata` unchanged. If `data_en=0`, the response is discarded.
- Flag clear: in any cycle with `longest_stall=0`, both `i_done` and `d_done` clear at the next edge.
  - The set (data_ok) takes precedence over the clear only if both happen in the same cycle.
- `addr_ok` or `data_ok` outside the matching state is ignored.

## Timing
- Reset values (async):
  - state = IDLE
  - `i_done = d_done = 0`
  - `req = wr = 0`, `size = 0`, `addr = wdata = 0`
  - `inst_rdata = data_rdata = 0`
- Minimum-latency sequence (request pending in cycle 0):
  - Cycle 0: IDLE, decision made.
  - Cycle 1: x_ADDR with `req=1`. If `addr_ok=1`, enter x_DATA at cycle 2.
  - `data_ok` in cycle 2: data is captured and the flag set at the edge into cycle 3. The stall is low in cycle 3.
- Unloaded fetch costs 3 stall cycles plus bus wait cycles.
- There is one IDLE bubble between back-to-back transactions.
- When both sides are pending, the fetch starts only after the data transaction completes. The fetch response is held in `inst_rdata` for as long as `longest_stall=1`.
- The held data stays valid and is not re-requested until the clearing edge. The next request of the same side can start one cycle after the clear.

## Test plan
- **Single fetch.**
  - Stimulus: `inst_en=1`, `inst_addr=0xBFC00000`; `addr_ok` 2 cycles after `req`; `data_ok` 3 cycles later with `rdata=0x3C08BFAF`.
  - Required: `req=1`, `wr=0`, `size=2`, `addr=0xBFC00000`; `instrStall` low the cycle after `data_ok`; `inst_rdata=0x3C08BFAF`.
- **Simultaneous requests.**
  - Stimulus: `inst_en=1` and `data_en=1` (read, addr 0x80000004) asserted in the same cycle.
  - Required: the first `req` carries addr 0x80000004. The fetch `req` follows after the data `data_ok`, with exactly one IDLE cycle between. `dataStall` falls before `instrStall`.
- **Byte and half writes.**
  - Stimulus: `data_wen=0100`, `data_addr=0x80000012`, `wdata=0x00AB0000`.
  - Required: `wr=1`, `size=0`, `addr=0x80000012`.
  - Stimulus: `data_wen=1100`, same address.
  - Required: `size=1`, `addr=0x80000012`; `data_rdata` unchanged.
- **Hold under global stall.**
  - Stimulus: fetch completes while `longest_stall=1` is held 10 more cycles.
  - Required: `i_done=1` throughout, no second fetch `req`, `inst_rdata` stable. After `longest_stall=0` for one cycle, `i_done=0` and a new fetch starts one cycle later.
- **Exception drop.**
  - Stimulus: `inst_en` falls during I_DATA.
  - Required: the transaction completes on `data_ok`; `inst_rdata` is not updated; `i_done` stays 0; no `instrStall`.
- **Reset mid-transaction.**
  - Stimulus: `rst` pulsed asynchronously while in D_DATA.
  - Required: immediately `req=0`, state IDLE, all registered outputs zero. After release with `data_en=1`, a fresh D_ADDR starts.
